sn_mem_responder: RTL and testbench
===================================

Name: sn_mem_responder

Overview:
- Subordinate-node (SN) endpoint for the 2x2 AXI-over-NoC fabric. Sits at the SN side of one crosspoint.
- Accepts AW, W and AR flits from NoC egress and executes them against an internal 64-bit-word memory.
- Returns B and R flits to NoC ingress. Each response tgtid equals the srcid of the originating request.
- NoC egress has no backpressure, so the ingress FIFOs must absorb traffic. An overflow is flagged, never silently hidden.

Parameters:
- MEM_WORDS, 256, number of 64-bit memory words (power of two).
- FIFO_DEPTH, 4, entries in each of the AW, W and AR ingress FIFOs (power of two, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- aw_valid  in  1  AW flit present
- aw_payload  in  82  [7:0] id, [15:8] len (beats-1), [47:16] byte addr, rest reserved
- aw_srcid  in  2  requesting RN
- aw_ready  out  1  AW FIFO not full (informational; NoC ignores it)
- w_valid  in  1  W flit present
- w_head  in  1  first beat of burst
- w_tail  in  1  last beat of burst
- w_payload  in  82  [63:0] data, [71:64] byte strobe, rest reserved
- w_srcid  in  2  requesting RN
- w_ready  out  1  W FIFO not full
- ar_valid  in  1  AR flit present
- ar_payload  in  82  same layout as aw_payload
- ar_srcid  in  2  requesting RN
- ar_ready  out  1  AR FIFO not full
- b_valid  out  1  B flit valid
- b_payload  out  20  [7:0] id, [9:8] resp, rest 0
- b_tgtid  out  2  destination RN
- b_ready  in  1  NoC accepts B
- r_valid  out  1  R flit valid
- r_head  out  1  first beat
- r_tail  out  1  last beat
- r_payload  out  82  [63:0] data, [71:64] id, [73:72] resp, rest 0
- r_tgtid  out  2  destination RN
- r_ready  in  1  NoC accepts R
- err_overflow  out  1  sticky: a flit arrived while its FIFO was full

Behaviour:
- Reset (sync, rst high at posedge):
  - FIFOs emptied; FSMs go to IDLE.
  - b_valid, r_valid, r_head, r_tail and err_overflow are 0. All payloads and tgtids are 0.
  - Ready outputs are 1 from the first cycle after reset. Memory contents are not reset.
  - Reset mid-burst aborts the burst; the pending response is discarded.
- FIFO push:
  - A FIFO pushes whenever its valid is high and it is not full.
  - valid while full: flit dropped, err_overflow set (cleared only by rst).
  - ready = !full.
  - A flit pushed in cycle N is visible at the FIFO head in N+1.
- Write FSM: W_IDLE -> W_DATA -> W_RESP.
  - W_IDLE: with AW head valid, latch id/len/addr/srcid, pop AW, beat=0, go to W_DATA.
  - W_DATA: each cycle W head is valid, pop one W flit.
    - If beat<=len and the word is in range: write memory[(addr>>3)+beat] with per-byte strobe.
    - Out-of-range beats and beats beyond len are not written.
    - A flit with w_tail=1 ends the phase -> W_RESP.
  - W_RESP: b_valid=1 and is held with stable payload until b_ready=1, then -> W_IDLE.
  - resp priority: DECERR 2'b11 (any beat word index >= MEM_WORDS) > SLVERR 2'b10 (tail beat count != len+1, or first flit lacks w_head) > OKAY 2'b00.
  - b_tgtid = latched aw_srcid.
  - b_valid first rises 1 cycle after the tail flit is popped.
- Read FSM: R_IDLE -> R_DATA.
  - R_IDLE: with AR head valid, latch fields, pop AR, beat=0, go to R_DATA.
  - R_DATA: register a beat whenever no beat is held or r_ready=1.
    - data = memory[(addr>>3)+beat], or 0 if out of range.
    - r_head = (beat==0); r_tail = (beat==len).
    - resp = DECERR if the beat is out of range, else OKAY.
    - r_tgtid = latched ar_srcid.
  - r_valid stays high with stable fields until r_ready; back-to-back beats are allowed when r_ready stays 1.
  - After the tail beat is accepted -> R_IDLE.
  - First r_valid is 2 cycles after the AR push cycle.
- Independence and ordering:
  - Write and read paths run concurrently.
  - Same-word write and read in the same cycle: the read returns the old data.
- Addressing: addr[2:0] ignored; INCR bursts; word index arithmetic is 32-bit with no wrap.
- Single outstanding burst per path; request ordering is FIFO per channel.

Test Plan:
1. Single write, then read:
   - AW id=0x12 len=0 addr=0x40 srcid=2; one W flit head=tail=1, data=0xDEADBEEF_CAFEF00D, strb=0xFF.
   - Expect: one b_valid cycle, b_payload[9:0]={OKAY,0x12}, b_tgtid=2.
   - Then AR addr=0x40 len=0 srcid=1: r_valid with head=tail=1, that data, r_tgtid=1.
2. Burst with backpressure:
   - Write 4 beats at addr 0x0 (len=3), then AR len=3 with r_ready toggling 1,0,1,0...
   - Expect: 4 beats in order, each held stable while r_ready=0, head only on beat 0, tail only on beat 3.
3. Strobe merge:
   - Write 0xFFFF...FF strb=0xFF, then 0x0 strb=0x0F at the same addr.
   - Read back expects 0xFFFFFFFF_00000000.
4. Length mismatch:
   - AW len=3 followed by only 2 W flits, tail on the 2nd.
   - Expect B resp=SLVERR; the next burst proceeds normally.
5. Out of range:
   - AR addr=(MEM_WORDS-1)*8 len=1.
   - Expect beat0 OKAY with data; beat1 DECERR with data 0.
6. Overflow and reset:
   - Push 5 AR flits on consecutive cycles while the read FSM is stalled with r_ready=0.
   - Expect ar_ready=0 after the 4th push and err_overflow=1.
   - rst pulse clears err_overflow and r_valid, and ar_ready=1.

Source files
------------

// File: rtl/sn_mem_responder.sv
// sn_mem_responder: subordinate-node memory endpoint for the AXI-over-NoC fabric.
// AW, W and AR flits from the NoC egress go into small ingress FIFOs. Writes and
// reads are executed against an internal 64-bit word memory. B and R flits go back
// to the NoC ingress, addressed to the requesting RN.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   aw_* / w_* / ar_*                request flits in; *_ready = FIFO not full
//   b_*                              write response out (valid held until b_ready)
//   r_*                              read data out (valid held until r_ready)
//   err_overflow                     sticky: a flit arrived while its FIFO was full

module sn_mem_responder_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [PW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (PW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rptr_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 1'b1;
         if (pop_ok)  rptr_q <= rptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= data_i;
   end
endmodule

// Write FSM          | Read FSM
// state  | meaning   | state  | meaning
// W_IDLE | wait AW   | R_IDLE | wait AR; issues beat 0 while popping
// W_DATA | drain W   | R_DATA | issue remaining beats, wait tail accept
// W_RESP | hold B    |
module sn_mem_responder #(
   parameter int MEM_WORDS  = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        aw_valid,
   input  logic [81:0] aw_payload,
   input  logic [1:0]  aw_srcid,
   output logic        aw_ready,
   input  logic        w_valid,
   input  logic        w_head,
   input  logic        w_tail,
   input  logic [81:0] w_payload,
   input  logic [1:0]  w_srcid,
   output logic        w_ready,
   input  logic        ar_valid,
   input  logic [81:0] ar_payload,
   input  logic [1:0]  ar_srcid,
   output logic        ar_ready,
   output logic        b_valid,
   output logic [19:0] b_payload,
   output logic [1:0]  b_tgtid,
   input  logic        b_ready,
   output logic        r_valid,
   output logic        r_head,
   output logic        r_tail,
   output logic [81:0] r_payload,
   output logic [1:0]  r_tgtid,
   input  logic        r_ready,
   output logic        err_overflow
);
   localparam int          IDX_W   = $clog2(MEM_WORDS);
   localparam logic [31:0] WORDS_L = 32'(MEM_WORDS);
   localparam logic [1:0]  OKAY    = 2'b00;
   localparam logic [1:0]  SLVERR  = 2'b10;
   localparam logic [1:0]  DECERR  = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

   // Ingress FIFOs; AW/AR entries are {srcid, addr, len, id}, W is {tail, head, strb, data}
   logic [49:0] aw_head_e, ar_head_e;
   logic [73:0] w_head_e;
   logic        aw_empty, aw_full, w_empty, w_full, ar_empty, ar_full;
   logic        aw_pop, w_pop, ar_pop;

   sn_mem_responder_fifo #(.WIDTH(50), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
      .clk(clk), .rst(rst), .push_i(aw_valid),
      .data_i({aw_srcid, aw_payload[47:0]}), .pop_i(aw_pop),
      .data_o(aw_head_e), .empty_o(aw_empty), .full_o(aw_full));

   sn_mem_responder_fifo #(.WIDTH(74), .DEPTH(FIFO_DEPTH)) u_w_fifo (
      .clk(clk), .rst(rst), .push_i(w_valid),
      .data_i({w_tail, w_head, w_payload[71:0]}), .pop_i(w_pop),
      .data_o(w_head_e), .empty_o(w_empty), .full_o(w_full));

   sn_mem_responder_fifo #(.WIDTH(50), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
      .clk(clk), .rst(rst), .push_i(ar_valid),
      .data_i({ar_srcid, ar_payload[47:0]}), .pop_i(ar_pop),
      .data_o(ar_head_e), .empty_o(ar_empty), .full_o(ar_full));

   assign aw_ready = !aw_full;
   assign w_ready  = !w_full;
   assign ar_ready = !ar_full;

   logic unused_bits;
   assign unused_bits = ^{aw_payload[81:48], ar_payload[81:48], w_payload[81:72], w_srcid};

   logic err_q;
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if ((aw_valid && aw_full) || (w_valid && w_full) || (ar_valid && ar_full))
         err_q <= 1'b1;
   end
   assign err_overflow = err_q;

   logic [63:0] mem_q [MEM_WORDS];

   // ---------------- write path ----------------
   w_state_t    w_state_q, w_state_d;
   logic [7:0]  w_id_q, w_id_d, w_len_q, w_len_d;
   logic [31:0] w_base_q, w_base_d, w_beat_q, w_beat_d, w_idx;
   logic [1:0]  w_src_q, w_src_d, b_resp_q, b_resp_d;
   logic        w_dec_q, w_dec_d, w_slv_q, w_slv_d, w_dec_n, w_slv_n, mem_we;

   assign w_idx = w_base_q + w_beat_q;

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_len_d   = w_len_q;
      w_base_d  = w_base_q;
      w_beat_d  = w_beat_q;
      w_src_d   = w_src_q;
      w_dec_d   = w_dec_q;
      w_slv_d   = w_slv_q;
      b_resp_d  = b_resp_q;
      w_dec_n   = w_dec_q;
      w_slv_n   = w_slv_q;
      aw_pop    = 1'b0;
      w_pop     = 1'b0;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (!aw_empty) begin
            aw_pop    = 1'b1;
            w_id_d    = aw_head_e[7:0];
            w_len_d   = aw_head_e[15:8];
            w_base_d  = {3'b000, aw_head_e[47:19]};
            w_src_d   = aw_head_e[49:48];
            w_beat_d  = '0;
            w_dec_d   = 1'b0;
            w_slv_d   = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (!w_empty) begin
            w_pop   = 1'b1;
            mem_we  = (w_beat_q <= {24'd0, w_len_q}) && (w_idx < WORDS_L) && !rst;
            w_dec_n = w_dec_q || (w_idx >= WORDS_L);
            w_slv_n = w_slv_q || ((w_beat_q == '0) && !w_head_e[72]);
            if (w_head_e[73]) begin
               // beat count at the tail must equal len+1
               w_slv_n   = w_slv_n || (w_beat_q != {24'd0, w_len_q});
               b_resp_d  = w_dec_n ? DECERR : (w_slv_n ? SLVERR : OKAY);
               w_state_d = W_RESP;
            end
            w_dec_d  = w_dec_n;
            w_slv_d  = w_slv_n;
            w_beat_d = w_beat_q + 32'd1;
         end
         W_RESP: if (b_ready) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_len_q   <= '0;
         w_base_q  <= '0;
         w_beat_q  <= '0;
         w_src_q   <= '0;
         w_dec_q   <= 1'b0;
         w_slv_q   <= 1'b0;
         b_resp_q  <= OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_len_q   <= w_len_d;
         w_base_q  <= w_base_d;
         w_beat_q  <= w_beat_d;
         w_src_q   <= w_src_d;
         w_dec_q   <= w_dec_d;
         w_slv_q   <= w_slv_d;
         b_resp_q  <= b_resp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 8; b++) begin
            if (w_head_e[64+b]) mem_q[w_idx[IDX_W-1:0]][8*b +: 8] <= w_head_e[8*b +: 8];
         end
      end
   end

   assign b_valid   = (w_state_q == W_RESP);
   assign b_payload = b_valid ? {10'd0, b_resp_q, w_id_q} : '0;
   assign b_tgtid   = b_valid ? w_src_q : '0;

   // ---------------- read path ----------------
   r_state_t    r_state_q, r_state_d;
   logic [7:0]  r_id_q, r_id_d, r_len_q, r_len_d;
   logic [31:0] r_base_q, r_base_d, r_beat_q, r_beat_d, r_iss_idx;
   logic [1:0]  r_src_q, r_src_d, r_resp_q, r_resp_d;
   logic        r_valid_q, r_valid_d, r_head_q, r_head_d, r_tail_q, r_tail_d, r_issue;
   logic [63:0] r_data_q;

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_base_d  = r_base_q;
      r_beat_d  = r_beat_q;
      r_src_d   = r_src_q;
      r_valid_d = r_valid_q;
      r_head_d  = r_head_q;
      r_tail_d  = r_tail_q;
      r_resp_d  = r_resp_q;
      r_iss_idx = '0;
      r_issue   = 1'b0;
      ar_pop    = 1'b0;
      case (r_state_q)
         // Beat 0 is issued straight from the AR head to save a cycle of latency.
         R_IDLE: if (!ar_empty) begin
            ar_pop    = 1'b1;
            r_id_d    = ar_head_e[7:0];
            r_len_d   = ar_head_e[15:8];
            r_base_d  = {3'b000, ar_head_e[47:19]};
            r_src_d   = ar_head_e[49:48];
            r_iss_idx = {3'b000, ar_head_e[47:19]};
            r_issue   = 1'b1;
            r_head_d  = 1'b1;
            r_tail_d  = (ar_head_e[15:8] == 8'd0);
            r_beat_d  = 32'd1;
            r_valid_d = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (r_valid_q && r_ready) begin
               r_valid_d = 1'b0;
               if (r_tail_q) r_state_d = R_IDLE;
            end
            if ((!r_valid_q || r_ready) && (r_beat_q <= {24'd0, r_len_q})) begin
               r_iss_idx = r_base_q + r_beat_q;
               r_issue   = 1'b1;
               r_head_d  = (r_beat_q == '0);
               r_tail_d  = (r_beat_q == {24'd0, r_len_q});
               r_beat_d  = r_beat_q + 32'd1;
               r_valid_d = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (r_issue) r_resp_d = (r_iss_idx < WORDS_L) ? OKAY : DECERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_base_q  <= '0;
         r_beat_q  <= '0;
         r_src_q   <= '0;
         r_valid_q <= 1'b0;
         r_head_q  <= 1'b0;
         r_tail_q  <= 1'b0;
         r_resp_q  <= OKAY;
         r_data_q  <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_base_q  <= r_base_d;
         r_beat_q  <= r_beat_d;
         r_src_q   <= r_src_d;
         r_valid_q <= r_valid_d;
         r_head_q  <= r_head_d;
         r_tail_q  <= r_tail_d;
         r_resp_q  <= r_resp_d;
         // memory read sees pre-write contents on a same-cycle collision
         if (r_issue) r_data_q <= (r_iss_idx < WORDS_L) ? mem_q[r_iss_idx[IDX_W-1:0]] : '0;
      end
   end

   assign r_valid   = r_valid_q;
   assign r_head    = r_valid_q && r_head_q;
   assign r_tail    = r_valid_q && r_tail_q;
   assign r_payload = r_valid_q ? {8'd0, r_resp_q, r_id_q, r_data_q} : '0;
   assign r_tgtid   = r_valid_q ? r_src_q : '0;
endmodule

// File: tb/tb_sn_mem_responder.sv
module tb_sn_mem_responder;
   localparam int MW = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
   logic [81:0] aw_payload = '0, w_payload = '0, ar_payload = '0;
   logic [1:0]  aw_srcid = '0, w_srcid = '0, ar_srcid = '0;
   logic        w_head = 1'b0, w_tail = 1'b0;
   logic        aw_ready, w_ready, ar_ready;
   logic        b_valid, r_valid, r_head, r_tail, err_overflow;
   logic [19:0] b_payload;
   logic [81:0] r_payload;
   logic [1:0]  b_tgtid, r_tgtid;
   logic        b_ready = 1'b1, r_ready = 1'b1;
   logic        rr_tog = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [21:0] exp_b [$];
   logic [85:0] exp_r [$];
   logic [63:0] mdl [MW];
   logic [21:0] mon_eb;
   logic [85:0] mon_er;

   always #5 clk = ~clk;

   sn_mem_responder #(.MEM_WORDS(MW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .aw_valid(aw_valid), .aw_payload(aw_payload), .aw_srcid(aw_srcid), .aw_ready(aw_ready),
      .w_valid(w_valid), .w_head(w_head), .w_tail(w_tail), .w_payload(w_payload),
      .w_srcid(w_srcid), .w_ready(w_ready),
      .ar_valid(ar_valid), .ar_payload(ar_payload), .ar_srcid(ar_srcid), .ar_ready(ar_ready),
      .b_valid(b_valid), .b_payload(b_payload), .b_tgtid(b_tgtid), .b_ready(b_ready),
      .r_valid(r_valid), .r_head(r_head), .r_tail(r_tail), .r_payload(r_payload),
      .r_tgtid(r_tgtid), .r_ready(r_ready), .err_overflow(err_overflow));

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(posedge clk) if (rr_tog) begin
      #1 r_ready = ~r_ready;
   end

   always @(negedge clk) begin
      if (!rst && b_valid && b_ready) begin
         if (exp_b.size() == 0) chk("b_unexpected", exp_b.size(), 1);
         else begin
            mon_eb = exp_b.pop_front();
            chk("b_flit", {b_tgtid, b_payload}, mon_eb);
         end
      end
      if (!rst && r_valid && r_ready) begin
         if (exp_r.size() == 0) chk("r_unexpected", exp_r.size(), 1);
         else begin
            mon_er = exp_r.pop_front();
            chk("r_flit", {r_tgtid, r_head, r_tail, r_payload}, mon_er);
         end
      end
   end

   task automatic write_burst(input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr,
                              input logic [1:0] src, input int nfl, input logic [63:0] base,
                              input logic [7:0] strb);
      logic        dec, slv;
      logic [31:0] idx;
      logic [63:0] d;
      logic [1:0]  resp;
      dec = 1'b0;
      for (int k = 0; k < nfl; k++) begin
         idx = (addr >> 3) + 32'(k);
         d   = base + 64'(k);
         if (idx >= MW) dec = 1'b1;
         else if (k <= int'(len)) begin
            for (int b = 0; b < 8; b++) if (strb[b]) mdl[idx[7:0]][8*b +: 8] = d[8*b +: 8];
         end
      end
      slv  = (nfl != int'(len) + 1);
      resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
      exp_b.push_back({src, 10'd0, resp, id});
      @(posedge clk); #1;
      aw_valid   = 1'b1;
      aw_payload = {34'd0, addr, len, id};
      aw_srcid   = src;
      for (int k = 0; k < nfl; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            aw_valid = 1'b0;
         end
         w_valid   = 1'b1;
         w_head    = (k == 0);
         w_tail    = (k == nfl - 1);
         w_payload = {10'd0, strb, base + 64'(k)};
         w_srcid   = src;
      end
      @(posedge clk); #1;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      w_head   = 1'b0;
      w_tail   = 1'b0;
   endtask

   task automatic read_burst(input logic [7:0] id, input logic [7:0] len, input logic [31:0] addr,
                             input logic [1:0] src);
      logic [31:0] idx;
      logic        inr;
      for (int k = 0; k <= int'(len); k++) begin
         idx = (addr >> 3) + 32'(k);
         inr = (idx < MW);
         exp_r.push_back({src, (k == 0), (k == int'(len)), 8'd0, (inr ? 2'b00 : 2'b11), id,
                          (inr ? mdl[idx[7:0]] : 64'd0)});
      end
      @(posedge clk); #1;
      ar_valid   = 1'b1;
      ar_payload = {34'd0, addr, len, id};
      ar_srcid   = src;
      @(posedge clk); #1;
      ar_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 300 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(posedge clk);
      chk(tag, exp_b.size() + exp_r.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_b_valid", b_valid, 0);
      chk("rst_r_valid", {r_valid, r_head, r_tail}, 0);
      chk("rst_err", err_overflow, 0);
      chk("rst_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
      chk("rst_payloads", {b_payload, b_tgtid, r_payload, r_tgtid}, 0);

      // 1: single write then read, with latency checks
      write_burst(8'h12, 8'd0, 32'h40, 2'd2, 1, 64'hDEADBEEF_CAFEF00D, 8'hFF);
      @(posedge clk); #1 chk("t1_b_early", b_valid, 0);
      @(posedge clk); #1 chk("t1_b_rise", b_valid, 1);
      drain("t1_wdrain");
      read_burst(8'h21, 8'd0, 32'h40, 2'd1);
      chk("t1_r_early", r_valid, 0);
      @(posedge clk); #1 chk("t1_r_rise", r_valid, 1);
      drain("t1_rdrain");

      // 2: 4-beat burst, read back with r_ready toggling
      write_burst(8'h33, 8'd3, 32'h0, 2'd0, 4, 64'h1111_2222_3333_4440, 8'hFF);
      drain("t2_wdrain");
      rr_tog = 1'b1;
      read_burst(8'h34, 8'd3, 32'h0, 2'd3);
      drain("t2_rdrain");
      rr_tog = 1'b0;
      @(posedge clk); #1 r_ready = 1'b1;

      // 3: strobe merge
      write_burst(8'h40, 8'd0, 32'h80, 2'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      drain("t3_w1");
      write_burst(8'h41, 8'd0, 32'h80, 2'd1, 1, 64'h0, 8'h0F);
      drain("t3_w2");
      read_burst(8'h42, 8'd0, 32'h80, 2'd2);
      drain("t3_r");

      // 4: length mismatch, then a normal burst
      write_burst(8'h44, 8'd3, 32'h100, 2'd0, 2, 64'hABCD_0000_0000_0010, 8'hFF);
      drain("t4_w1");
      write_burst(8'h45, 8'd1, 32'h200, 2'd3, 2, 64'h5555_0000_0000_0020, 8'hFF);
      drain("t4_w2");
      read_burst(8'h46, 8'd1, 32'h100, 2'd0);
      read_burst(8'h47, 8'd1, 32'h200, 2'd1);
      drain("t4_r");

      // 5: read straddling the end of memory
      write_burst(8'h50, 8'd0, 32'((MW - 1) * 8), 2'd2, 1, 64'h0123_4567_89AB_CDEF, 8'hFF);
      drain("t5_w");
      read_burst(8'h51, 8'd1, 32'((MW - 1) * 8), 2'd2);
      drain("t5_r");

      // 6: stall the read path, overflow the AR FIFO, then reset
      r_ready = 1'b0;
      read_burst(8'h60, 8'd0, 32'h40, 2'd3);
      for (int i = 0; i < 20 && !r_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("t6_stalled", r_valid, 1);
      @(posedge clk); #1;
      ar_valid   = 1'b1;
      ar_payload = {34'd0, 32'h40, 8'd0, 8'h61};
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (k == 3) begin
            chk("t6_ar_full", ar_ready, 0);
            chk("t6_no_err_yet", err_overflow, 0);
         end
      end
      ar_valid = 1'b0;
      chk("t6_err", err_overflow, 1);
      chk("t6_r_held", r_valid, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_r.delete();
      chk("t6_rst_err", err_overflow, 0);
      chk("t6_rst_rvalid", r_valid, 0);
      chk("t6_rst_ready", ar_ready, 1);
      r_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("t6_no_stale", r_valid, 0);
      read_burst(8'h62, 8'd0, 32'h40, 2'd0);
      drain("t6_recover");

      chk("sb_b_left", exp_b.size(), 0);
      chk("sb_r_left", exp_r.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
